// File: rtl/board_shuffler_pkg.sv
// Shared constants, state encoding and LFSR step for the tile board shuffler.
package board_shuffler_pkg;

  localparam int          NUM_TILES  = 16;
  localparam int          VAL_W      = 3;
  localparam int          TILE_IDX_W = 4;
  localparam int          MAX_REJECT = 8;
  localparam logic [15:0] LFSR_POLY  = 16'hB400;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  typedef enum logic [1:0] {IDLE, INIT, SHUFFLE, DONE} state_e;

  // One right-shifting Galois step; taps are folded in when the LSB falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR with a seed-mix load path.
// A zero load value would lock the register, so it is replaced by the seed.
module lfsr16
  import board_shuffler_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        advance,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] state
);

  // Load has priority over stepping; zero loads fall back to the seed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     state <= SEED;
    else if (load)    state <= (load_val == 16'h0) ? SEED : load_val;
    else if (advance) state <= lfsr_next(state);
  end

endmodule

// File: rtl/board_shuffler.sv
// Builds a shuffled board of value pairs with a bounded Fisher-Yates pass.
// Draws that land above idx are retried; after MAX_REJECT misses in a row the
// draw is folded into range by dropping its top mask bit.
module board_shuffler #(
  parameter int          NUM_TILES  = board_shuffler_pkg::NUM_TILES,
  parameter int          VAL_W      = board_shuffler_pkg::VAL_W,
  parameter logic [15:0] LFSR_SEED  = board_shuffler_pkg::LFSR_SEED,
  parameter int          MAX_REJECT = board_shuffler_pkg::MAX_REJECT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [15:0]                seed_mix,
  output logic [NUM_TILES*VAL_W-1:0] tile_values_flat,
  output logic                       busy,
  output logic                       done,
  output logic                       valid
);
  import board_shuffler_pkg::*;

  localparam int IDX_W = $clog2(NUM_TILES);
  localparam int REJ_W = (MAX_REJECT > 1) ? $clog2(MAX_REJECT) : 1;

  state_e                              state, state_nxt;
  logic [NUM_TILES-1:0][VAL_W-1:0]     tiles, tiles_nxt;
  logic [IDX_W-1:0]                    idx, idx_nxt;
  logic [REJ_W-1:0]                    rej, rej_nxt;
  logic [IDX_W-1:0]                    mask, r, j;
  logic                                take;
  logic [15:0]                         lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk      (clk),
    .reset_n  (reset_n),
    .advance  (!start),
    .load     (start),
    .load_val (lfsr ^ seed_mix),
    .state    (lfsr)
  );

  // Smallest all-ones mask covering idx: smear the top set bit downward.
  always_comb begin
    mask = idx;
    for (int s = 1; s < IDX_W; s = s * 2) mask = mask | (mask >> s);
  end

  assign r = lfsr[IDX_W-1:0] & mask;

  // Next-state, draw acceptance and swap; a start overrides everything.
  always_comb begin
    state_nxt = state;
    tiles_nxt = tiles;
    idx_nxt   = idx;
    rej_nxt   = rej;
    j         = r;
    take      = 1'b0;
    case (state)
      IDLE: ;
      INIT: begin
        for (int i = 0; i < NUM_TILES; i++) tiles_nxt[i] = VAL_W'(i >> 1);
        idx_nxt   = '1;
        rej_nxt   = '0;
        state_nxt = SHUFFLE;
      end
      SHUFFLE: begin
        if (r <= idx) begin
          take = 1'b1;
        end else if (rej == REJ_W'(MAX_REJECT - 1)) begin
          take = 1'b1;
          j    = r & (mask >> 1);
        end else begin
          rej_nxt = rej + 1'b1;
        end
        if (take) begin
          tiles_nxt[idx] = tiles[j];
          tiles_nxt[j]   = tiles[idx];
          idx_nxt        = idx - 1'b1;
          rej_nxt        = '0;
          if (idx == IDX_W'(1)) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = INIT;
  end

  // Board, index and retry counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      tiles <= '0;
      idx   <= '0;
      rej   <= '0;
    end else begin
      state <= state_nxt;
      tiles <= tiles_nxt;
      idx   <= idx_nxt;
      rej   <= rej_nxt;
    end
  end

  // Valid rises as DONE retires and drops on any accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            valid <= 1'b0;
    else if (start)          valid <= 1'b0;
    else if (state == DONE)  valid <= 1'b1;
  end

  assign busy             = (state == INIT) || (state == SHUFFLE);
  assign done             = (state == DONE);
  assign tile_values_flat = tiles;

endmodule
